// File: rtl/proc_ctrl_fsm_pkg.sv
// Shared types and constants for the multi-cycle processor control unit.
package proc_ctrl_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_ADDR,
      ST_MEM_RD,
      ST_MEM_WR,
      ST_WB,
      ST_JMP,
      ST_HALT
   } state_e;

   typedef enum logic [2:0] {
      CLS_NOP,
      CLS_R,
      CLS_LOAD,
      CLS_STORE,
      CLS_JUMP,
      CLS_BEQ,
      CLS_HALT,
      CLS_ILLEGAL
   } op_class_e;

   localparam int unsigned OP_NOP   = 'h00;
   localparam int unsigned OP_R_LO  = 'h01;
   localparam int unsigned OP_R_HI  = 'h0F;
   localparam int unsigned OP_LOAD  = 'h10;
   localparam int unsigned OP_STORE = 'h11;
   localparam int unsigned OP_JUMP  = 'h12;
   localparam int unsigned OP_BEQ   = 'h13;
   localparam int unsigned OP_HALT  = 'h3F;

   localparam int unsigned SEL_MEM = 0;
   localparam int unsigned SEL_ALU = 1;
   localparam int unsigned SEL_PC  = 2;
   localparam int unsigned SEL_IMM = 3;

endpackage

// File: rtl/proc_ctrl_fsm_if.sv
// Control-unit <-> datapath signal bundle; master is the control FSM.
interface proc_ctrl_fsm_if #(
   parameter int unsigned ISA_DPTH   = 64,
   parameter int unsigned MUX_SEL_SZ = 2,
   parameter int unsigned CNT_WIDTH  = 32
);
   localparam int unsigned OPW = $clog2(ISA_DPTH);

   logic [OPW-1:0]        i_opcd;
   logic                  i_mem_rdy;
   logic                  i_alu_zero;
   logic                  o_ir_e;
   logic                  o_pc_e;
   logic                  o_ld_pc;
   logic                  o_mem_we;
   logic                  o_mem_addr_sel;
   logic [MUX_SEL_SZ-1:0] o_mux_sel;
   logic                  o_reg_we;
   logic [OPW-1:0]        o_alu_op;
   logic                  o_illegal;
   logic                  o_halted;
   logic [CNT_WIDTH-1:0]  o_retired;

   modport master (
      input  i_opcd, i_mem_rdy, i_alu_zero,
      output o_ir_e, o_pc_e, o_ld_pc, o_mem_we, o_mem_addr_sel, o_mux_sel,
             o_reg_we, o_alu_op, o_illegal, o_halted, o_retired
   );

   modport slave (
      output i_opcd, i_mem_rdy, i_alu_zero,
      input  o_ir_e, o_pc_e, o_ld_pc, o_mem_we, o_mem_addr_sel, o_mux_sel,
             o_reg_we, o_alu_op, o_illegal, o_halted, o_retired
   );
endinterface

// File: rtl/proc_ctrl_fsm_op_class.sv
// Combinational opcode-to-instruction-class decoder.
module proc_op_class
   import proc_ctrl_pkg::*;
#(
   parameter int unsigned OPW = 6
) (
   input  logic [OPW-1:0] i_opcd,
   output op_class_e      o_class
);

   always_comb begin
      o_class = CLS_ILLEGAL;
      if (i_opcd == OPW'(OP_NOP))
         o_class = CLS_NOP;
      else if (i_opcd >= OPW'(OP_R_LO) && i_opcd <= OPW'(OP_R_HI))
         o_class = CLS_R;
      else if (i_opcd == OPW'(OP_LOAD))
         o_class = CLS_LOAD;
      else if (i_opcd == OPW'(OP_STORE))
         o_class = CLS_STORE;
      else if (i_opcd == OPW'(OP_JUMP))
         o_class = CLS_JUMP;
      else if (i_opcd == OPW'(OP_BEQ))
         o_class = CLS_BEQ;
      else if (i_opcd == OPW'(OP_HALT))
         o_class = CLS_HALT;
   end

endmodule

// File: rtl/proc_ctrl_fsm.sv
// Multi-cycle control FSM: sequences FETCH/DECODE/EXEC/MEM/WB and drives datapath strobes.
module proc_ctrl_fsm
   import proc_ctrl_pkg::*;
#(
   parameter int unsigned ISA_DPTH   = 64,
   parameter int unsigned MUX_SEL_SZ = 2,
   parameter int unsigned CNT_WIDTH  = 32
) (
   input logic             clk,
   input logic             rst_n,
   proc_ctrl_fsm_if.master io_ctrl
);
   localparam int unsigned OPW = $clog2(ISA_DPTH);

   state_e                r_state;
   state_e                w_next;
   logic [OPW-1:0]        r_opcd;
   logic [OPW-1:0]        w_cls_opcd;
   logic [CNT_WIDTH-1:0]  r_retired;
   op_class_e             w_cls;
   logic                  w_retire;
   logic                  w_ir_e;
   logic                  w_pc_e;
   logic                  w_ld_pc;
   logic                  w_mem_we;
   logic                  w_mem_addr_sel;
   logic [MUX_SEL_SZ-1:0] w_mux_sel;
   logic                  w_reg_we;
   logic                  w_illegal;
   logic                  w_halted;

   // One decoder serves both the live opcode in DECODE and the latched one afterwards.
   assign w_cls_opcd = (r_state == ST_DECODE) ? io_ctrl.i_opcd : r_opcd;

   proc_op_class #(.OPW(OPW)) u_op_class (
      .i_opcd  (w_cls_opcd),
      .o_class (w_cls)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_opcd    <= '0;
         r_retired <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == ST_DECODE)
            r_opcd <= io_ctrl.i_opcd;
         if (w_retire)
            r_retired <= r_retired + CNT_WIDTH'(1);
      end
   end

   always_comb begin
      w_next         = r_state;
      w_retire       = 1'b0;
      w_ir_e         = 1'b0;
      w_pc_e         = 1'b0;
      w_ld_pc        = 1'b0;
      w_mem_we       = 1'b0;
      w_mem_addr_sel = 1'b0;
      w_mux_sel      = MUX_SEL_SZ'(SEL_MEM);
      w_reg_we       = 1'b0;
      w_illegal      = 1'b0;
      w_halted       = 1'b0;
      unique case (r_state)
         ST_IDLE: w_next = ST_FETCH;
         ST_FETCH: begin
            w_ir_e = io_ctrl.i_mem_rdy;
            w_pc_e = io_ctrl.i_mem_rdy;
            if (io_ctrl.i_mem_rdy)
               w_next = ST_DECODE;
         end
         ST_DECODE: begin
            unique case (w_cls)
               CLS_NOP:              begin w_next = ST_FETCH; w_retire = 1'b1; end
               CLS_R, CLS_BEQ:       w_next = ST_EXEC;
               CLS_LOAD, CLS_STORE:  w_next = ST_ADDR;
               CLS_JUMP:             w_next = ST_JMP;
               CLS_HALT:             begin w_next = ST_HALT; w_retire = 1'b1; end
               default:              begin w_next = ST_FETCH; w_illegal = 1'b1; end
            endcase
         end
         ST_EXEC: begin
            if (w_cls == CLS_BEQ) begin
               w_ld_pc  = io_ctrl.i_alu_zero;
               w_next   = ST_FETCH;
               w_retire = 1'b1;
            end else begin
               w_next = ST_WB;
            end
         end
         ST_ADDR: w_next = (w_cls == CLS_LOAD) ? ST_MEM_RD : ST_MEM_WR;
         ST_MEM_RD: begin
            w_mem_addr_sel = 1'b1;
            if (io_ctrl.i_mem_rdy)
               w_next = ST_WB;
         end
         ST_MEM_WR: begin
            w_mem_addr_sel = 1'b1;
            w_mem_we       = io_ctrl.i_mem_rdy;
            if (io_ctrl.i_mem_rdy) begin
               w_next   = ST_FETCH;
               w_retire = 1'b1;
            end
         end
         ST_WB: begin
            w_reg_we  = 1'b1;
            w_mux_sel = (w_cls == CLS_LOAD) ? MUX_SEL_SZ'(SEL_MEM) : MUX_SEL_SZ'(SEL_ALU);
            w_next    = ST_FETCH;
            w_retire  = 1'b1;
         end
         ST_JMP: begin
            w_ld_pc   = 1'b1;
            w_mux_sel = MUX_SEL_SZ'(SEL_IMM);
            w_next    = ST_FETCH;
            w_retire  = 1'b1;
         end
         ST_HALT: w_halted = 1'b1;
         default: w_next = ST_IDLE;
      endcase
   end

   assign io_ctrl.o_ir_e         = w_ir_e;
   assign io_ctrl.o_pc_e         = w_pc_e;
   assign io_ctrl.o_ld_pc        = w_ld_pc;
   assign io_ctrl.o_mem_we       = w_mem_we;
   assign io_ctrl.o_mem_addr_sel = w_mem_addr_sel;
   assign io_ctrl.o_mux_sel      = w_mux_sel;
   assign io_ctrl.o_reg_we       = w_reg_we;
   assign io_ctrl.o_alu_op       = r_opcd;
   assign io_ctrl.o_illegal      = w_illegal;
   assign io_ctrl.o_halted       = w_halted;
   assign io_ctrl.o_retired      = r_retired;

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// Randomized bench for proc_ctrl_fsm against an instruction-level reference model.
module tb_proc_ctrl_fsm;

   localparam int K_NOP   = 0;
   localparam int K_R     = 1;
   localparam int K_LOAD  = 2;
   localparam int K_STORE = 3;
   localparam int K_JUMP  = 4;
   localparam int K_BEQ   = 5;
   localparam int K_ILL   = 6;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   proc_ctrl_fsm_if #(.ISA_DPTH(64), .MUX_SEL_SZ(2), .CNT_WIDTH(32)) u_if ();

   proc_ctrl_fsm #(.ISA_DPTH(64), .MUX_SEL_SZ(2), .CNT_WIDTH(32)) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .io_ctrl (u_if.master)
   );

   // {ir_e, pc_e, ld_pc, mem_we, addr_sel, mux_sel[1:0], reg_we, illegal, halted}
   logic [9:0] w_strb;
   assign w_strb = {u_if.o_ir_e, u_if.o_pc_e, u_if.o_ld_pc, u_if.o_mem_we, u_if.o_mem_addr_sel,
                    u_if.o_mux_sel, u_if.o_reg_we, u_if.o_illegal, u_if.o_halted};

   int unsigned n_checks;
   int unsigned n_fail;
   logic [31:0] exp_ret;
   logic [5:0]  exp_alu;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=0x%0h required=0x%0h", tag, act, exp);
      end
   endtask

   function automatic int unsigned base_lat(input int kind);
      case (kind)
         K_R:     return 4;
         K_LOAD:  return 5;
         K_STORE: return 4;
         K_JUMP:  return 3;
         K_BEQ:   return 3;
         default: return 2;
      endcase
   endfunction

   function automatic logic [5:0] pick_op(input int kind);
      case (kind)
         K_R:     return 6'($urandom_range(1, 15));
         K_LOAD:  return 6'h10;
         K_STORE: return 6'h11;
         K_JUMP:  return 6'h12;
         K_BEQ:   return 6'h13;
         K_ILL:   return 6'($urandom_range(20, 62));
         default: return 6'h00;
      endcase
   endfunction

   // Runs one instruction for exactly its expected cycle count, with f_st fetch
   // stalls and m_st memory stalls, then compares per-instruction strobe totals.
   task automatic run_instr(input int kind, input logic [5:0] opc, input bit zero,
                            input int unsigned f_st, input int unsigned m_st, input string tag);
      int unsigned n;
      bit          is_mem;
      int unsigned ir_cnt, pc_cnt, ldpc_cnt, we_cnt, asel_cnt, rw_cnt, imm_cnt, ill_cnt, hlt_cnt, both_cnt;
      int unsigned ir_k, ldpc_k, we_k, rw_k, ill_k;
      logic [1:0]  rw_mux;
      is_mem = (kind == K_LOAD) || (kind == K_STORE);
      n = base_lat(kind) + f_st + (is_mem ? m_st : 0);
      {ir_cnt, pc_cnt, ldpc_cnt, we_cnt, asel_cnt, rw_cnt, imm_cnt, ill_cnt, hlt_cnt, both_cnt} = '0;
      {ir_k, ldpc_k, we_k, rw_k, ill_k} = {5{32'hFFFF}};
      rw_mux = 2'bxx;
      for (int unsigned k = 0; k < n; k++) begin
         @(negedge clk);
         u_if.i_mem_rdy  = 1'($urandom_range(0, 1));
         u_if.i_opcd     = 6'($urandom_range(0, 63));
         u_if.i_alu_zero = 1'($urandom_range(0, 1));
         if (k <= f_st) u_if.i_mem_rdy = (k == f_st);
         if (k == f_st + 1) u_if.i_opcd = opc;
         if (kind == K_BEQ && k == f_st + 2) u_if.i_alu_zero = zero;
         if (is_mem && k >= f_st + 3 && k <= f_st + 3 + m_st) u_if.i_mem_rdy = (k == f_st + 3 + m_st);
         #1;
         if (k == 0) begin
            check({tag, ".retired"}, 64'(u_if.o_retired), 64'(exp_ret));
            check({tag, ".alu_op"}, 64'(u_if.o_alu_op), 64'(exp_alu));
         end
         if (u_if.o_ir_e) begin ir_cnt++; ir_k = k; end
         if (u_if.o_pc_e) pc_cnt++;
         if (u_if.o_ld_pc) begin ldpc_cnt++; ldpc_k = k; end
         if (u_if.o_pc_e && u_if.o_ld_pc) both_cnt++;
         if (u_if.o_mem_we) begin we_cnt++; we_k = k; end
         if (u_if.o_mem_addr_sel) asel_cnt++;
         if (u_if.o_reg_we) begin rw_cnt++; rw_k = k; rw_mux = u_if.o_mux_sel; end
         if (u_if.o_mux_sel == 2'd3) imm_cnt++;
         if (u_if.o_illegal) begin ill_cnt++; ill_k = k; end
         if (u_if.o_halted) hlt_cnt++;
      end
      check({tag, ".ir_cnt"}, 64'(ir_cnt), 64'(1));
      check({tag, ".ir_k"}, 64'(ir_k), 64'(f_st));
      check({tag, ".pc_cnt"}, 64'(pc_cnt), 64'(1));
      check({tag, ".pc_ldpc_overlap"}, 64'(both_cnt), 64'(0));
      check({tag, ".ldpc_cnt"}, 64'(ldpc_cnt), 64'((kind == K_JUMP || (kind == K_BEQ && zero)) ? 1 : 0));
      if (ldpc_cnt == 1) check({tag, ".ldpc_k"}, 64'(ldpc_k), 64'(n - 1));
      check({tag, ".we_cnt"}, 64'(we_cnt), 64'((kind == K_STORE) ? 1 : 0));
      if (kind == K_STORE) check({tag, ".we_k"}, 64'(we_k), 64'(n - 1));
      check({tag, ".addr_sel_cnt"}, 64'(asel_cnt), 64'(is_mem ? m_st + 1 : 0));
      check({tag, ".reg_we_cnt"}, 64'(rw_cnt), 64'((kind == K_R || kind == K_LOAD) ? 1 : 0));
      if (kind == K_R || kind == K_LOAD) begin
         check({tag, ".reg_we_k"}, 64'(rw_k), 64'(n - 1));
         check({tag, ".wb_mux"}, 64'(rw_mux), 64'((kind == K_R) ? 1 : 0));
      end
      check({tag, ".imm_cnt"}, 64'(imm_cnt), 64'((kind == K_JUMP) ? 1 : 0));
      check({tag, ".illegal_cnt"}, 64'(ill_cnt), 64'((kind == K_ILL) ? 1 : 0));
      if (kind == K_ILL) check({tag, ".illegal_k"}, 64'(ill_k), 64'(f_st + 1));
      check({tag, ".halted_cnt"}, 64'(hlt_cnt), 64'(0));
      if (kind != K_ILL) exp_ret = exp_ret + 32'd1;
      exp_alu = opc;
   endtask

   task automatic idle_after_release(input string tag);
      @(negedge clk);
      rst_n = 1'b1;
      u_if.i_mem_rdy = 1'b1;
      #1;
      check({tag, ".idle_strb"}, 64'(w_strb), 64'(0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int kind;
      n_checks = 0;
      n_fail   = 0;
      exp_ret  = '0;
      exp_alu  = '0;
      u_if.i_mem_rdy  = 1'b1;
      u_if.i_opcd     = '0;
      u_if.i_alu_zero = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("reset.strb", 64'(w_strb), 64'(0));
      check("reset.retired", 64'(u_if.o_retired), 64'(0));
      check("reset.alu_op", 64'(u_if.o_alu_op), 64'(0));
      idle_after_release("boot");

      for (int i = 0; i < 5; i++) run_instr(K_NOP, 6'h00, 1'b0, 0, 0, "nop");
      run_instr(K_R, 6'h05, 1'b0, 0, 0, "r05");
      run_instr(K_LOAD, 6'h10, 1'b0, 0, 3, "load_wait3");
      run_instr(K_STORE, 6'h11, 1'b0, 0, 0, "store");
      run_instr(K_BEQ, 6'h13, 1'b1, 0, 0, "beq_taken");
      run_instr(K_BEQ, 6'h13, 1'b0, 0, 0, "beq_not");
      run_instr(K_ILL, 6'h20, 1'b0, 0, 0, "illegal20");
      run_instr(K_JUMP, 6'h12, 1'b0, 0, 0, "jump");

      for (int i = 0; i < 40; i++) begin
         kind = int'($urandom_range(0, 6));
         run_instr(kind, pick_op(kind), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3), $urandom_range(0, 3), $sformatf("rnd%0d", i));
      end

      // Reset while a store waits on memory: nothing may be written.
      @(negedge clk); u_if.i_mem_rdy = 1'b1; #1;
      @(negedge clk); u_if.i_mem_rdy = 1'b0; u_if.i_opcd = 6'h11; #1;
      @(negedge clk); u_if.i_mem_rdy = 1'b0; #1;
      @(negedge clk); u_if.i_mem_rdy = 1'b0; #1;
      check("mw_wait.addr_sel", 64'(u_if.o_mem_addr_sel), 64'(1));
      check("mw_wait.mem_we", 64'(u_if.o_mem_we), 64'(0));
      #1 rst_n = 1'b0;
      #1;
      check("mw_rst.strb", 64'(w_strb), 64'(0));
      u_if.i_mem_rdy = 1'b1;
      #1;
      check("mw_rst.mem_we", 64'(u_if.o_mem_we), 64'(0));
      repeat (2) begin
         @(negedge clk); #1;
         check("mw_rst.hold_strb", 64'(w_strb), 64'(0));
      end
      check("mw_rst.retired", 64'(u_if.o_retired), 64'(0));
      check("mw_rst.alu_op", 64'(u_if.o_alu_op), 64'(0));
      exp_ret = '0;
      exp_alu = '0;
      idle_after_release("mw_rst");

      run_instr(K_R, 6'h0F, 1'b0, 1, 0, "post_rst_r");
      @(negedge clk); u_if.i_mem_rdy = 1'b1; #1;
      check("halt.retired_pre", 64'(u_if.o_retired), 64'(exp_ret));
      @(negedge clk); u_if.i_opcd = 6'h3F; #1;
      check("halt.decode_strb", 64'(w_strb), 64'(0));
      exp_ret = exp_ret + 32'd1;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         u_if.i_mem_rdy  = 1'($urandom_range(0, 1));
         u_if.i_opcd     = 6'($urandom_range(0, 63));
         u_if.i_alu_zero = 1'($urandom_range(0, 1));
         #1;
         check($sformatf("halt.strb%0d", i), 64'(w_strb), 64'(10'b0000000001));
      end
      check("halt.retired", 64'(u_if.o_retired), 64'(exp_ret));
      check("halt.alu_op", 64'(u_if.o_alu_op), 64'(6'h3F));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/proc_ctrl_fsm.md
Name: proc_ctrl_fsm

Overview:
Multi-cycle control unit for the processor datapath. It consumes the opcode parsed from the instruction register and drives the datapath control strobes: IR load, PC increment/load, memory write, mux select, register-file write and ALU op. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states, waits on memory readiness, and flags illegal opcodes and halt.

Parameters:
ISA_DPTH, 64, number of opcodes; opcode width OPW = $clog2(ISA_DPTH) = 6
MUX_SEL_SZ, 2, width of datapath data-mux select
CNT_WIDTH, 32, width of retired-instruction counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active low
i_opcd  in  OPW  opcode from instruction parser; valid in DECODE
i_mem_rdy  in  1  memory access completes this cycle
i_alu_zero  in  1  ALU result is zero (branch compare)
o_ir_e  out  1  instruction register load enable
o_pc_e  out  1  PC increment enable
o_ld_pc  out  1  PC load (jump/branch target)
o_mem_we  out  1  memory write enable
o_mem_addr_sel  out  1  0 = PC addresses memory, 1 = ALU result addresses memory
o_mux_sel  out  MUX_SEL_SZ  data mux select: 0 mem data, 1 ALU result, 2 PC, 3 immediate
o_reg_we  out  1  register-file write enable
o_alu_op  out  OPW  latched opcode to the ALU
o_illegal  out  1  one-cycle pulse on undefined opcode
o_halted  out  1  high while in HALT
o_retired  out  CNT_WIDTH  count of retired instructions

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, ADDR, MEM_RD, MEM_WR, WB, JMP, HALT. Registered state; outputs decoded from state (plus i_mem_rdy where noted).
- Reset (async, rst_n low): state = IDLE, opcode latch = 0, o_retired = 0. In IDLE all outputs are 0 and o_mux_sel = 0. IDLE -> FETCH unconditionally on the next clock.
- FETCH: o_mem_addr_sel = 0, o_mux_sel = 0. o_ir_e = o_pc_e = i_mem_rdy. Stays in FETCH while i_mem_rdy = 0; -> DECODE when i_mem_rdy = 1.
- DECODE: opcode latch <= i_opcd; o_alu_op follows the latch from the next cycle. Next state by i_opcd:
  - 6'h00 NOP -> FETCH (retire)
  - 6'h01..6'h0F R-type -> EXEC
  - 6'h10 LOAD / 6'h11 STORE -> ADDR
  - 6'h12 JUMP -> JMP
  - 6'h13 BEQ -> EXEC
  - 6'h3F HALT -> HALT
  - any other value: o_illegal = 1 for this cycle, -> FETCH, no retire.
- EXEC: R-type -> WB. BEQ: o_ld_pc = i_alu_zero, -> FETCH (retire).
- WB: o_reg_we = 1, o_mux_sel = 1 for R-type and 0 for LOAD. -> FETCH (retire).
- ADDR: ALU computes the address. LOAD -> MEM_RD; STORE -> MEM_WR.
- MEM_RD: o_mem_addr_sel = 1. Waits on i_mem_rdy; -> WB when i_mem_rdy = 1.
- MEM_WR: o_mem_addr_sel = 1, o_mem_we = i_mem_rdy. Waits on i_mem_rdy; -> FETCH (retire) when i_mem_rdy = 1.
- JMP: o_ld_pc = 1, o_mux_sel = 3. -> FETCH (retire).
- HALT: o_halted = 1, all strobes 0. Only reset leaves HALT. Counts as retired once, on entry.
- Minimum latency with i_mem_rdy tied to 1:
  - NOP: 2 cycles
  - R-type: 4 cycles
  - LOAD: 5 cycles
  - STORE: 4 cycles
  - JUMP: 3 cycles
  - BEQ: 3 cycles
- o_retired increments by 1 on the cycle the FSM leaves the final state of an instruction. It wraps modulo 2^CNT_WIDTH.
- At most one of o_pc_e and o_ld_pc is asserted in any cycle.
- o_mem_we is never asserted outside MEM_WR.
- Reset asserted mid-instruction (any state): immediate return to IDLE. No partial write completes after reset is asserted.

Decomposition:
- Package proc_ctrl_pkg holds:
  - the state enum
  - opcode localparams: OP_NOP, OP_LOAD, OP_STORE, OP_JUMP, OP_BEQ, OP_HALT, and the R-type range bounds
  - mux-select localparams: SEL_MEM, SEL_ALU, SEL_PC, SEL_IMM
- One sub-module, proc_op_class: combinational opcode-to-class decoder (R, LOAD, STORE, JUMP, BEQ, NOP, HALT, ILLEGAL). It is used in DECODE and in the later states on the latched opcode.

Test Plan:
- Reset, release, i_mem_rdy = 1, NOP stream -> IDLE for 1 cycle, then o_ir_e/o_pc_e high every 2nd cycle; o_retired = 5 after 11 cycles.
- R-type opcode 6'h05 -> o_reg_we = 1 with o_mux_sel = 1 exactly in cycle 4 of the instruction; o_alu_op = 6'h05.
- LOAD with i_mem_rdy low for 3 cycles in MEM_RD -> FSM holds with o_mem_addr_sel = 1, then WB with o_mux_sel = 0, o_reg_we = 1; total 8 cycles.
- STORE then BEQ with i_alu_zero = 1 then BEQ with i_alu_zero = 0 -> exactly one o_mem_we pulse; o_ld_pc pulses once; o_pc_e is never coincident with o_ld_pc.
- Illegal opcode 6'h20 -> one-cycle o_illegal, o_retired unchanged, next FETCH follows.
- HALT 6'h3F -> o_halted stays high for 20+ cycles with no strobes. rst_n pulsed mid-MEM_WR while i_mem_rdy = 0 -> outputs 0 immediately and no o_mem_we.
